// File: rtl/jk_ff_bank.sv
// Bank of JK/T/D flip-flops advanced by a divided clock-enable tick, with
// synchronised j/k inputs, per-channel set/clear and a change-detect pulse.
module jk_ff_bank #(
    parameter int WIDTH       = 4,
    parameter int DIV         = 50000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] set,
    input  logic [WIDTH-1:0] clr,
    output logic             tick,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             changed
);

    localparam int             CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_T    = 2'b01,
        MODE_D    = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qb_q;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] j_s, k_s;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);

    // j and k share one pipeline; SYNC_STAGES=0 feeds the raw inputs straight in.
    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign j_s = j;
            assign k_s = k;
        end else begin : g_sync
            logic [2*WIDTH-1:0] sync_q [SYNC_STAGES];
            logic [2*WIDTH-1:0] sync_d [SYNC_STAGES];

            always_comb begin
                sync_d[0] = {k, j};
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    sync_d[s] = sync_q[s-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        sync_q[s] <= '0;
                    end
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign j_s = sync_q[SYNC_STAGES-1][WIDTH-1:0];
            assign k_s = sync_q[SYNC_STAGES-1][2*WIDTH-1:WIDTH];
        end
    endgenerate

    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = 1'b0;
        if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // clr beats set, and both beat the tick-gated mode update.
    always_comb begin
        q_d = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (clr[i]) begin
                q_d[i] = 1'b0;
            end else if (set[i]) begin
                q_d[i] = 1'b1;
            end else if (tick_q) begin
                case (mode_sel)
                    MODE_JK: begin
                        case ({j_s[i], k_s[i]})
                            2'b01:   q_d[i] = 1'b0;
                            2'b10:   q_d[i] = 1'b1;
                            2'b11:   q_d[i] = ~q_q[i];
                            default: q_d[i] = q_q[i];
                        endcase
                    end
                    MODE_T: begin
                        if (j_s[i]) begin
                            q_d[i] = ~q_q[i];
                        end
                    end
                    MODE_D:  q_d[i] = j_s[i];
                    default: q_d[i] = q_q[i];
                endcase
            end
        end
        changed_d = (q_d != q_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            q_q       <= '0;
            qb_q      <= '1;
            changed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            q_q       <= q_d;
            qb_q      <= ~q_d;
            changed_q <= changed_d;
        end
    end

    assign tick    = tick_q;
    assign q       = q_q;
    assign qb      = qb_q;
    assign changed = changed_q;

endmodule

// File: doc/jk_ff_bank.md
Name: jk_ff_bank

Overview:
- Parametrised bank of WIDTH JK-style flip-flops for board-level demos, driven from the 100 MHz board clock.
- State updates only on an internal divided tick, implemented as a clock enable; no derived clock.
- Adds a runtime mode (JK / T / D / hold), per-channel synchronous set/clear that bypass the tick, input synchronisers for slide switches, and a change-detect pulse for downstream LED/counter logic.

Parameters:
- WIDTH, 4, number of flip-flop channels (>=1).
- DIV, 50000000, clk cycles per tick (>=1); tick-counter width is derived as clog2(DIV), minimum 1.
- SYNC_STAGES, 2, synchroniser depth on j and k (0..4; 0 = bypass).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- j  in  WIDTH  J input per channel; also the T input in T mode and the D input in D mode. Asynchronous; passes through the synchroniser.
- k  in  WIDTH  K input per channel; ignored outside JK mode. Asynchronous; passes through the synchroniser.
- mode  in  2  00=JK, 01=T, 10=D, 11=hold. Synchronous to clk; not synchronised.
- set  in  WIDTH  per-channel synchronous preset. Synchronous to clk.
- clr  in  WIDTH  per-channel synchronous clear. Synchronous to clk.
- tick  out  1  registered one-cycle enable pulse, every DIV cycles.
- q  out  WIDTH  flip-flop state.
- qb  out  WIDTH  complement of q.
- changed  out  1  registered one-cycle pulse when any q bit changed on the previous edge.

Behaviour:
- Reset, while rst=1 at an edge: cnt=0, tick=0, q=0, qb=all ones, changed=0, synchroniser stages=0. rst overrides every other input.
- Divider:
  - At each edge with rst=0: if cnt==DIV-1 then cnt<=0 and tick<=1; else cnt<=cnt+1 and tick<=0.
  - The first tick is high in the cycle after the DIV-th edge following reset release, and then every DIV cycles.
  - DIV=1: tick=1 every cycle after the first edge following reset release.
- Synchroniser: j_s/k_s are j/k delayed by SYNC_STAGES edges. An input change therefore affects q no earlier than the first tick-gated update at least SYNC_STAGES+1 edges after the change.
- Per-channel next-state, evaluated at each edge, in priority order:
  1. rst: q<=0.
  2. clr[i]: q[i]<=0. clr wins over set when both are asserted.
  3. set[i]: q[i]<=1.
  4. tick=1, mode-dependent:
     - JK: j_s=0,k_s=0 hold; j_s=0,k_s=1 -> 0; j_s=1,k_s=0 -> 1; j_s=1,k_s=1 -> toggle.
     - T: toggle when j_s[i]=1.
     - D: q[i]<=j_s[i].
     - hold: no change.
  5. Otherwise: hold.
- set/clr act on the next edge regardless of tick. If set/clr and tick coincide on a channel, set/clr wins; other channels update normally.
- mode is sampled at the tick edge; a mode change between ticks has no effect until the next tick.
- qb is a registered copy of ~q, updated on the same edge. q and qb are never equal.
- changed<=1 on any edge where next q != current q, whether caused by tick or by set/clr; otherwise 0. rst forces changed=0 even if q changes.
- Reset mid-count: cnt restarts from 0; any pending tick is dropped.
- No wrap issues: cnt never exceeds DIV-1.

Test Plan:
All scenarios use WIDTH=4, DIV=4, SYNC_STAGES=2 unless noted.
1. rst=1 for 3 cycles, then release -> q=0000, qb=1111, tick=0, changed=0 during reset; tick high exactly on cycles 4, 8, 12 after release.
2. JK mode, j=0011, k=0101 held from reset -> first tick edge: q=0011 (b0 toggle, b1 set, b2 clear, b3 hold), changed=1; next tick: q=0010; following tick: q=0011.
3. T mode, q=0000, j=1010 -> successive ticks give q=1010, 0000, 1010; changed pulses once per tick.
4. D mode, j=0110 -> q=0110 at first tick with changed=1; later ticks with j unchanged leave changed=0. Then set j=1001 one cycle before a tick -> no update at that tick (synchroniser latency); q=1001 at the following tick.
5. With q=0000, set=1111 and clr=0001 for one cycle between ticks -> q=1110, qb=0001 on the next edge; changed=1. Then set=0001 coinciding with a JK tick where j=0,k=1 on b0 -> q[0]=1.
6. Assert rst at cnt=2 with q=1111 -> q=0000 and changed=0 on that edge; next tick 4 cycles after release. Rerun with DIV=1 -> tick=1 every cycle and D mode tracks j_s each cycle.
